// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream system reset. Retries on lock timeout, re-sequences
// when lock is lost while running, and latches a failure once the retry
// budget is spent.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int GLITCH_CYCLES       = 4,
   parameter int RETRY_LIMIT         = 0
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       lock_lost,
   output logic       fail,
   output logic [7:0] retry_count,
   output logic [2:0] state
);

   localparam logic [2:0] S_PLLRST = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_STABLE = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_FAIL   = 3'd4;

   // One shared counter, sized for the longest interval it must time.
   localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > GLITCH_CYCLES) ? LOCK_TIMEOUT_CYCLES : GLITCH_CYCLES;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GLT_LAST = CNT_W'(GLITCH_CYCLES - 1);
   localparam logic [31:0]      RETRY_LIM = 32'(RETRY_LIMIT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic [2:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [7:0]             retry_q, retry_d;
   logic                   lost_d;
   logic                   pll_rst_q, sys_rst_n_q, lock_lost_q, fail_q;

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Bring the asynchronous PLL lock into the clkin domain.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   // Next-state, counter and retry logic; restart overrides every other event.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      retry_d = retry_q;
      lost_d  = 1'b0;
      if (restart) begin
         state_d = S_PLLRST;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            S_PLLRST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end
            end
            S_WAIT: begin
               if (locked_s) begin
                  // The cycle that first sees lock already counts toward stability.
                  state_d = S_STABLE;
                  cnt_d   = CNT_ONE;
               end else if (cnt_q == TMO_LAST) begin
                  cnt_d = '0;
                  if ((RETRY_LIM != 32'd0) && ((32'(retry_q) + 32'd1) >= RETRY_LIM)) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_PLLRST;
                     if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                     end
                  end
               end
            end
            S_STABLE: begin
               if (!locked_s) begin
                  state_d = S_WAIT;
                  cnt_d   = '0;
               end else if (cnt_q == STB_LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end
            end
            S_RUN: begin
               // Counter tracks consecutive unlocked cycles only.
               if (locked_s) begin
                  cnt_d = '0;
               end else if (cnt_q == GLT_LAST) begin
                  state_d = S_PLLRST;
                  cnt_d   = '0;
                  lost_d  = 1'b1;
               end
            end
            S_FAIL: begin
               cnt_d = '0;
            end
            default: begin
               state_d = S_PLLRST;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State registers; outputs are registered from the next state so they
   // change on the same edge as the transition.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PLLRST;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= (state_d == S_PLLRST);
         sys_rst_n_q <= (state_d == S_RUN);
         lock_lost_q <= lost_d;
         fail_q      <= (state_d == S_FAIL);
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign lock_lost   = lock_lost_q;
   assign fail        = fail_q;
   assign retry_count = retry_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a vector table for the nominal
// bring-up plus hand-written sequences for glitches, bounces, timeouts,
// restart priority and asynchronous reset.
module tb_pll_reset_sequencer;

   logic       clkin = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       restart;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       lock_lost;
   logic       fail;
   logic [7:0] retry_count;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES        (2),
      .PLL_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(32),
      .GLITCH_CYCLES      (3),
      .RETRY_LIMIT        (2)
   ) dut (
      .clkin      (clkin),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .lock_lost  (lock_lost),
      .fail       (fail),
      .retry_count(retry_count),
      .state      (state)
   );

   always #5 clkin = ~clkin;

   typedef struct packed {
      logic       locked;
      logic       rs;
      logic       prst;
      logic       srst;
      logic       ll;
      logic       fl;
      logic [7:0] rc;
      logic [2:0] st;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(logic locked, logic rs, logic prst, logic srst,
                               logic ll, logic fl, logic [7:0] rc, logic [2:0] st);
      vec_t v;
      v.locked = locked; v.rs = rs; v.prst = prst; v.srst = srst;
      v.ll = ll; v.fl = fl; v.rc = rc; v.st = st;
      return v;
   endfunction

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic check_out(input string name, input logic e_prst, input logic e_srst,
                            input logic e_ll, input logic e_fail, input logic [7:0] e_rc,
                            input logic [2:0] e_st);
      logic [14:0] act;
      logic [14:0] exp;
      act = {pll_rst, sys_rst_n, lock_lost, fail, retry_count, state};
      exp = {e_prst, e_srst, e_ll, e_fail, e_rc, e_st};
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got pll_rst=%b sys_rst_n=%b lock_lost=%b fail=%b retry_count=%0d state=%0d, want %b %b %b %b %0d %0d",
                  name, pll_rst, sys_rst_n, lock_lost, fail, retry_count, state,
                  e_prst, e_srst, e_ll, e_fail, e_rc, e_st);
      end else begin
         $display("[%0t] %s: ok (state=%0d rc=%0d)", $time, name, state, retry_count);
      end
   endtask

   // Expected outputs k edges after a restart with lock held low:
   // 4-cycle pulse, 32-cycle wait, second pulse (retry 1), 32-cycle wait, FAIL.
   task automatic check_timeout(input string tag, input int k);
      string nm;
      nm = $sformatf("%s k=%0d", tag, k);
      if (k <= 3)       check_out(nm, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      else if (k <= 35) check_out(nm, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
      else if (k <= 39) check_out(nm, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 3'd0);
      else if (k <= 71) check_out(nm, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd1);
      else              check_out(nm, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'd4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got t=%0t, want < 200000", $time);
      $fatal(1);
   end

   initial begin
      // Nominal bring-up: lock rises 2 cycles after pll_rst falls (edge 7);
      // STABLE at edge 9, RUN at edge 16 (10th edge counting the sampling one).
      vecs[0]  = mk(0, 0, 1, 0, 0, 0, 8'd0, 3'd0);
      vecs[1]  = mk(0, 0, 1, 0, 0, 0, 8'd0, 3'd0);
      vecs[2]  = mk(0, 0, 1, 0, 0, 0, 8'd0, 3'd0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 8'd0, 3'd1);
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 8'd0, 3'd1);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 8'd0, 3'd1);
      vecs[6]  = mk(1, 0, 0, 0, 0, 0, 8'd0, 3'd1);
      vecs[7]  = mk(1, 0, 0, 0, 0, 0, 8'd0, 3'd1);
      for (int i = 8; i <= 14; i++) vecs[i] = mk(1, 0, 0, 0, 0, 0, 8'd0, 3'd2);
      for (int i = 15; i <= 17; i++) vecs[i] = mk(1, 0, 0, 1, 0, 0, 8'd0, 3'd3);

      // Reset state, held across clock edges.
      rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out($sformatf("reset hold %0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         pll_locked = vecs[i].locked;
         restart    = vecs[i].rs;
         tick();
         check_out($sformatf("nominal row %0d", i + 1), vecs[i].prst, vecs[i].srst,
                   vecs[i].ll, vecs[i].fl, vecs[i].rc, vecs[i].st);
      end

      // Two-cycle unlock in RUN is filtered out.
      for (int j = 0; j < 8; j++) begin
         pll_locked = (j >= 2);
         tick();
         check_out($sformatf("glitch2 j=%0d", j), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3);
      end

      // Sustained unlock: third synced-low cycle (edge 4) triggers lock loss.
      pll_locked = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick();
         if (j <= 3)      check_out($sformatf("lockloss j=%0d", j), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3);
         else if (j == 4) check_out($sformatf("lockloss j=%0d", j), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0);
         else if (j <= 7) check_out($sformatf("lockloss j=%0d", j), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
         else             check_out($sformatf("lockloss j=%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
      end

      // Bounce in STABLE: high 5, low 1, high; back to WAIT_LOCK without a
      // PLL reset, release 10 edges after the second rise (sampled at j=6).
      for (int j = 0; j < 17; j++) begin
         pll_locked = (j != 5);
         tick();
         if (j <= 1)       check_out($sformatf("bounce j=%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
         else if (j <= 6)  check_out($sformatf("bounce j=%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
         else if (j == 7)  check_out($sformatf("bounce j=%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
         else if (j <= 14) check_out($sformatf("bounce j=%0d", j), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
         else              check_out($sformatf("bounce j=%0d", j), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3);
      end

      // Restart from RUN, one timeout (retry 1), then lock and run again.
      pll_locked = 1'b0; restart = 1'b1;
      tick();
      check_out("restart from run", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      restart = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         check_timeout("retry1", k);
      end
      pll_locked = 1'b1;
      for (int k = 41; k <= 52; k++) begin
         tick();
         if (k <= 42)      check_out($sformatf("relock k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd1);
         else if (k <= 49) check_out($sformatf("relock k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd2);
         else              check_out($sformatf("relock k=%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd3);
      end

      // Restart arriving on the same cycle as the glitch limit wins.
      pll_locked = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_out($sformatf("glitch+restart pre k=%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd3);
      end
      restart = 1'b1;
      tick();
      check_out("glitch+restart same cycle", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      restart = 1'b0;

      // Lock held low: two timeouts, the second one ends in FAIL.
      for (int k = 1; k <= 75; k++) begin
         tick();
         check_timeout("timeout", k);
      end
      restart = 1'b1;
      tick();
      check_out("restart from fail", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      restart = 1'b0;

      // Bring up to RUN again, then assert rst_n between edges.
      pll_locked = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k <= 3)       check_out($sformatf("rerun k=%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
         else if (k == 4)  check_out($sformatf("rerun k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
         else if (k <= 11) check_out($sformatf("rerun k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
         else              check_out($sformatf("rerun k=%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd3);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async reset no edge", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      tick();
      check_out("async reset held", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k <= 3)      check_out($sformatf("post reset k=%0d", k), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
         else if (k == 4) check_out($sformatf("post reset k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd1);
         else             check_out($sformatf("post reset k=%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
